// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port arbiter in front of a single-port memory bank with
//             registered read data. Port a is the fetch side and port b is the
//             load/store side. One access is in flight at a time, and it moves
//             through IDLE -> ACCESS (-> RESP for reads) -> IDLE.
//
//  Latency, counted from the grant cycle T:
//    write : the bank commits it at the end of T+1, and a new grant is
//            possible at T+2
//    read  : rvalid and rdata appear at T+3, and a new grant is possible at T+3
//
//  Parameters
//    word_size : data word width (default `DATA_WORD_SIZE)
//    addr_size : address width   (default `DATA_ADDR_SIZE)
//
//  Configuration macro
//    MEM_ARB_FIXED_PRIO_EN : when defined, port a always wins simultaneous
//                            requests and there is no priority pointer. When
//                            undefined, a 1-bit round-robin pointer is used.
//
//  Ports
//    clk, rst                 : clock and synchronous active-high reset
//    a_req / b_req            : access request, held until gnt is seen
//    a_we / b_we              : 1 = write, 0 = read
//    a_addr / b_addr          : access address
//    a_wdata / b_wdata        : write data
//    a_gnt / b_gnt            : combinational one-cycle grant pulse, in IDLE only
//    a_rdata / b_rdata        : registered read data, held until the next read
//    a_rvalid / b_rvalid      : one-cycle pulse when rdata has just updated
//    mem_w_en, mem_addr,
//    mem_d_in                 : bank command; w_en is high only in ACCESS
//    mem_d_out                : bank read data, one cycle after the address
//    busy                     : high in any state other than IDLE
//
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 8
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 4
`endif

module mem_arbiter #(
  parameter int word_size = `DATA_WORD_SIZE,
  parameter int addr_size = `DATA_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [addr_size-1:0] a_addr,
  input  logic [word_size-1:0] a_wdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [addr_size-1:0] b_addr,
  input  logic [word_size-1:0] b_wdata,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic [word_size-1:0] a_rdata,
  output logic [word_size-1:0] b_rdata,
  output logic                 a_rvalid,
  output logic                 b_rvalid,
  output logic                 mem_w_en,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_d_in,
  input  logic [word_size-1:0] mem_d_out,
  output logic                 busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;

  logic                 any_req;
  logic                 win_b;      // winner of this cycle's arbitration: 1 = port b
  logic                 grant;      // a grant is issued this cycle

  // Command captured in the grant cycle.
  logic                 lat_we;
  logic                 lat_port;   // 1 = port b owns the access in flight
  logic [addr_size-1:0] lat_addr;
  logic [word_size-1:0] lat_wdata;

  assign any_req = a_req | b_req;
  assign grant   = (state == IDLE) && any_req;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRIO_EN
  // Port a wins any tie. Port b wins only when it is the sole requester.
  assign win_b = b_req & ~a_req;
`else
  // prio_b is the pointer: 0 gives port a priority, 1 gives port b priority.
  // It only decides ties; a sole requester wins regardless of it.
  logic prio_b;

  assign win_b = (a_req & b_req) ? prio_b : b_req;

  // After any grant, the priority moves to the port that lost (or did not ask).
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (grant) begin
      prio_b <= ~win_b;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      // Writes finish once the bank has taken them. Reads need one more cycle
      // for the registered bank output.
      ACCESS:  state_nxt = lat_we ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    a_gnt    = grant & ~win_b;
    b_gnt    = grant &  win_b;
    busy     = (state != IDLE);
    // rst gates the write enable combinationally. A write that is in ACCESS
    // when reset arrives therefore never reaches the bank.
    mem_w_en = (state == ACCESS) && lat_we && !rst;
  end

  // Address and data come straight from the latches. They hold the last
  // granted command outside ACCESS.
  assign mem_addr = lat_addr;
  assign mem_d_in = lat_wdata;

  // --------------------------------------------------------------------------
  // Command latch: requester inputs are sampled only in the grant cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      lat_port  <= win_b;
      lat_we    <= win_b ? b_we    : a_we;
      lat_addr  <= win_b ? b_addr  : a_addr;
      lat_wdata <= win_b ? b_wdata : a_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read return. In RESP, the bank output is already valid for the address
  // presented in ACCESS. Only the owning port's rdata is loaded, and rvalid is
  // high for exactly the following cycle. Reset wins over RESP, so an
  // interrupted read never reports.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == RESP) begin
        if (lat_port) begin
          b_rdata  <= mem_d_out;
          b_rvalid <= 1'b1;
        end else begin
          a_rdata  <= mem_d_out;
          a_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
